prog_timer: RTL
===============

Name: prog_timer

Overview:
- Parametrised, programmable tick/clock-enable generator; successor to the fixed 1 s divider.
- Runtime-loadable period and mode select periodic single-cycle ticks, a square-wave toggle output, or a one-shot timeout.
- Feeds display refresh, debounce and slow-clock enables in the multi-cycle CPU top.
- Synchronous to the system clock; all outputs registered.

Parameters:
CNT_WIDTH, 32, width of counter and period register
DEFAULT_PERIOD, 25000000, period_r value after reset (cycles per terminal event)
DEFAULT_MODE, 2'b01, mode_r value after reset (toggle: 1 s square wave at 50 MHz)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
en  in  1  count enable (level)
load  in  1  one-cycle strobe: capture period_in/mode_in, restart
period_in  in  CNT_WIDTH  new period N; 0 treated as 1
mode_in  in  2  00 periodic, 01 toggle, 10 one-shot, 11 = periodic
tick  out  1  one-cycle pulse on each terminal event
wave  out  1  square wave, flips on each terminal event in toggle mode
done  out  1  one-shot expired (sticky)
count  out  CNT_WIDTH  current counter value

Behaviour:
- Reset (async, any time, including mid-count):
  - cnt=0, tick=0, wave=0, done=0.
  - period_r=DEFAULT_PERIOD (0 -> 1), mode_r=DEFAULT_MODE.
- Effective period Neff = max(period_r, 1).
- Terminal condition: en=1 and cnt==Neff-1 and not (mode_r==10 and done=1).
- Priority per edge: rst > load > en > hold.
- load=1 (regardless of en):
  - period_r<=period_in, mode_r<=mode_in.
  - cnt<=0, tick<=0, done<=0, wave<=0.
  - Any terminal event due in the same cycle is discarded.
- en=1, no load, non-terminal: cnt<=cnt+1, tick<=0.
- en=1, terminal:
  - cnt<=0, tick<=1 for exactly one cycle.
  - Mode 01: wave<=~wave.
  - Mode 10: done<=1.
- en=0: cnt, wave, done hold; tick<=0. Pausing does not reset phase.
- Mode 10 after done=1: cnt holds at 0, no further ticks until load.
- wave stays 0 in modes 00/10/11.
- Latency:
  - With en held high, the first tick is visible the cycle after the N-th rising edge following the load edge.
  - Ticks then repeat every Neff cycles.
  - Neff=1 gives tick=1 every cycle; in toggle mode wave flips every cycle.
- Counter width arithmetic:
  - cnt never exceeds Neff-1, so no wrap-around.
  - period_in = 2^CNT_WIDTH-1 is legal.
- count output = cnt register, directly.
- Mode change only via load; there is no mid-period mode switch.

Test Plan:
- Reset with defaults (override DEFAULT_PERIOD=4) -> mode toggle, wave flips every 4 cycles, tick pulses every 4 cycles; first tick 4 edges after rst deassert with en=1.
- load period_in=4, mode=00, en=1 -> tick high one cycle at edges 4, 8, 12 after load; count sequence 0,1,2,3,0; wave stays 0.
- load period_in=5, mode=10 -> single tick 5 edges after load, done=1 thereafter, count stays 0; second load clears done and re-arms.
- Period 0 and 1 -> tick high every cycle; in mode 01, wave alternates each cycle.
- Pause and reload:
  - N=6, en dropped at count=3 for 10 cycles -> count holds 3, no tick; next tick 3 cycles after en returns.
  - load asserted in the terminal cycle -> no tick, count=0.
- Assert rst asynchronously mid-count (count=2, wave=1) -> outputs zero immediately without waiting for an edge; period_r/mode_r return to defaults.

Source files
------------

// File: rtl/prog_timer.sv
// Programmable tick / clock-enable generator.
// A runtime-loadable period and mode select one of three behaviours:
// periodic single-cycle ticks, a square-wave toggle, or a one-shot timeout.
// All outputs come straight from registers.
module prog_timer #(
  parameter int unsigned          CNT_WIDTH      = 32,
  parameter logic [CNT_WIDTH-1:0] DEFAULT_PERIOD = CNT_WIDTH'(25000000),
  parameter logic [1:0]           DEFAULT_MODE   = 2'b01
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 load,
  input  logic [CNT_WIDTH-1:0] period_in,
  input  logic [1:0]           mode_in,
  output logic                 tick,
  output logic                 wave,
  output logic                 done,
  output logic [CNT_WIDTH-1:0] count
);

  localparam logic [1:0] MODE_TOGGLE  = 2'b01;
  localparam logic [1:0] MODE_ONESHOT = 2'b10;

  // A period of zero behaves exactly like a period of one.
  localparam logic [CNT_WIDTH-1:0] RST_PERIOD =
    (DEFAULT_PERIOD == '0) ? CNT_WIDTH'(1) : DEFAULT_PERIOD;

  logic [CNT_WIDTH-1:0] period_q, period_d;
  logic [1:0]           mode_q,   mode_d;
  logic [CNT_WIDTH-1:0] cnt_q,    cnt_d;
  logic                 tick_q,   tick_d;
  logic                 wave_q,   wave_d;
  logic                 done_q,   done_d;

  logic [CNT_WIDTH-1:0] n_eff_c;
  logic                 spent_c;
  logic                 terminal_c;

  // Effective period and terminal-event detection.
  always_comb begin
    n_eff_c    = (period_q == '0) ? CNT_WIDTH'(1) : period_q;
    spent_c    = (mode_q == MODE_ONESHOT) && done_q;
    terminal_c = en && !spent_c && (cnt_q == (n_eff_c - CNT_WIDTH'(1)));
  end

  // Next-state logic: load beats enable; an expired one-shot freezes the counter.
  always_comb begin
    period_d = period_q;
    mode_d   = mode_q;
    cnt_d    = cnt_q;
    tick_d   = 1'b0;
    wave_d   = wave_q;
    done_d   = done_q;

    if (load) begin
      period_d = period_in;
      mode_d   = mode_in;
      cnt_d    = '0;
      wave_d   = 1'b0;
      done_d   = 1'b0;
    end else if (en && !spent_c) begin
      if (terminal_c) begin
        cnt_d  = '0;
        tick_d = 1'b1;
        if (mode_q == MODE_TOGGLE) begin
          wave_d = ~wave_q;
        end
        if (mode_q == MODE_ONESHOT) begin
          done_d = 1'b1;
        end
      end else begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  // State registers with asynchronous reset to the parameterised defaults.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_q <= RST_PERIOD;
      mode_q   <= DEFAULT_MODE;
      cnt_q    <= '0;
      tick_q   <= 1'b0;
      wave_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      period_q <= period_d;
      mode_q   <= mode_d;
      cnt_q    <= cnt_d;
      tick_q   <= tick_d;
      wave_q   <= wave_d;
      done_q   <= done_d;
    end
  end

  assign tick  = tick_q;
  assign wave  = wave_q;
  assign done  = done_q;
  assign count = cnt_q;

endmodule
